// File: rtl/tcdm_traffic_pkg.sv
// Shared types and helpers for the TCDM traffic generator: FSM states,
// data pattern and saturating counter arithmetic.
package tcdm_traffic_pkg;

    localparam int ErrCntWidth = 16;
    localparam int PatWidth    = 64;

    typedef enum logic [2:0] {
        TG_IDLE  = 3'd0,
        TG_WRITE = 3'd1,
        TG_READ  = 3'd2,
        TG_DRAIN = 3'd3,
        TG_DONE  = 3'd4
    } tg_state_e;

    function automatic logic [PatWidth-1:0] pattern(input logic [PatWidth-1:0] addr,
                                                    input logic [PatWidth-1:0] seed);
        return addr ^ seed;
    endfunction

    function automatic logic [ErrCntWidth-1:0] sat_inc(input logic [ErrCntWidth-1:0] v);
        return (v == {ErrCntWidth{1'b1}}) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tcdm_traffic_checker.sv
// In-order read response checker: tracks the expected word index and keeps
// saturating mismatch and response counters.
module tcdm_traffic_checker
    import tcdm_traffic_pkg::*;
#(
    parameter int unsigned NumWords  = 16,
    parameter logic [31:0] BaseAddr  = 32'h0,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned IdWidth   = 1,
    parameter logic [31:0] Seed      = 32'hA5A5_5A5A,
    parameter int unsigned CntWidth  = $clog2(NumWords + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   active_i,
    input  logic                   r_valid_i,
    input  logic [DataWidth-1:0]   r_data_i,
    input  logic [IdWidth-1:0]     r_id_i,
    output logic [ErrCntWidth-1:0] err_cnt_o,
    output logic [ErrCntWidth-1:0] rsp_cnt_o,
    output logic [ErrCntWidth-1:0] rsp_cnt_next_o
);

    localparam logic [63:0] SeedExt = {Seed, Seed};

    logic [CntWidth-1:0]    j_q, j_d;
    logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;
    logic [ErrCntWidth-1:0] rsp_cnt_q, rsp_cnt_d;
    logic [AddrWidth-1:0]   exp_addr_s;
    logic [DataWidth-1:0]   exp_data_s;
    logic [IdWidth-1:0]     exp_id_s;
    logic                   rsp_full_s;

    // Expected word and next counter values for the response on this cycle.
    always_comb begin
        j_d        = j_q;
        err_cnt_d  = err_cnt_q;
        rsp_cnt_d  = rsp_cnt_q;
        exp_addr_s = AddrWidth'(BaseAddr) + (AddrWidth'(j_q) << 2);
        exp_data_s = DataWidth'(pattern(PatWidth'(exp_addr_s), SeedExt));
        exp_id_s   = IdWidth'(j_q);
        rsp_full_s = (rsp_cnt_q == ErrCntWidth'(NumWords));
        if (clear_i) begin
            j_d       = '0;
            err_cnt_d = '0;
            rsp_cnt_d = '0;
        end else if (r_valid_i) begin
            // Unexpected responses are errors but never advance the index.
            if (!active_i || rsp_full_s) begin
                err_cnt_d = sat_inc(err_cnt_q);
            end else begin
                j_d       = j_q + CntWidth'(1);
                rsp_cnt_d = rsp_cnt_q + 16'd1;
                if ((r_data_i != exp_data_s) || (r_id_i != exp_id_s)) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                end else begin
                    err_cnt_d = err_cnt_q;
                end
            end
        end else begin
            j_d = j_q;
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            j_q       <= '0;
            err_cnt_q <= '0;
            rsp_cnt_q <= '0;
        end else begin
            j_q       <= j_d;
            err_cnt_q <= err_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
        end
    end

    assign err_cnt_o      = err_cnt_q;
    assign rsp_cnt_o      = rsp_cnt_q;
    assign rsp_cnt_next_o = rsp_cnt_d;

endmodule

// File: rtl/tcdm_traffic_gen.sv
// TCDM bank-port initiator: writes a deterministic pattern into NumWords
// words, reads them back and counts mismatches in the response checker.
module tcdm_traffic_gen
    import tcdm_traffic_pkg::*;
#(
    parameter int unsigned NumWords  = 16,
    parameter logic [31:0] BaseAddr  = 32'h0,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned BeWidth   = DataWidth / 8,
    parameter int unsigned IdWidth   = 1,
    parameter logic [31:0] Seed      = 32'hA5A5_5A5A
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    output logic                 req_o,
    input  logic                 gnt_i,
    output logic [AddrWidth-1:0] add_o,
    output logic                 wen_o,
    output logic [DataWidth-1:0] data_o,
    output logic [BeWidth-1:0]   be_o,
    output logic [IdWidth-1:0]   id_o,
    input  logic [DataWidth-1:0] r_data_i,
    input  logic                 r_valid_i,
    input  logic [IdWidth-1:0]   r_id_i,
    output logic                 r_ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [15:0]          err_cnt_o,
    output logic [15:0]          rsp_cnt_o
);

    localparam int unsigned CntWidth = $clog2(NumWords + 1);
    localparam logic [63:0] SeedExt  = {Seed, Seed};

    tg_state_e              state_q, state_d;
    logic [CntWidth-1:0]    k_q, k_d, k_inc_s;
    logic                   req_q, req_d, wen_q, wen_d, busy_q, busy_d, done_q, done_d;
    logic [AddrWidth-1:0]   add_q, add_d;
    logic [DataWidth-1:0]   data_q, data_d;
    logic [BeWidth-1:0]     be_q, be_d;
    logic [IdWidth-1:0]     id_q, id_d;
    logic                   start_s, active_s, last_s;
    logic [ErrCntWidth-1:0] rsp_cnt_next_s;

    function automatic logic [AddrWidth-1:0] word_addr(input logic [CntWidth-1:0] idx);
        return AddrWidth'(BaseAddr) + (AddrWidth'(idx) << 2);
    endfunction

    function automatic logic [DataWidth-1:0] word_data(input logic [CntWidth-1:0] idx);
        return DataWidth'(pattern(PatWidth'(word_addr(idx)), SeedExt));
    endfunction

    assign start_s  = start_i && ((state_q == TG_IDLE) || (state_q == TG_DONE));
    assign active_s = (state_q == TG_READ) || (state_q == TG_DRAIN);

    // Next state and next request; an ungranted request keeps every field.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        req_d   = req_q;
        wen_d   = wen_q;
        add_d   = add_q;
        data_d  = data_q;
        be_d    = be_q;
        id_d    = id_q;
        busy_d  = busy_q;
        done_d  = done_q;
        k_inc_s = k_q + CntWidth'(1);
        last_s  = (k_q == CntWidth'(NumWords - 1));
        case (state_q)
            TG_IDLE, TG_DONE: begin
                if (start_s) begin
                    state_d = TG_WRITE;
                    k_d     = '0;
                    req_d   = 1'b1;
                    wen_d   = 1'b0;
                    add_d   = word_addr('0);
                    data_d  = word_data('0);
                    be_d    = '1;
                    id_d    = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            TG_WRITE: begin
                if (gnt_i && last_s) begin
                    state_d = TG_READ;
                    k_d     = '0;
                    wen_d   = 1'b1;
                    add_d   = word_addr('0);
                    data_d  = '0;
                    id_d    = '0;
                end else if (gnt_i) begin
                    k_d    = k_inc_s;
                    add_d  = word_addr(k_inc_s);
                    data_d = word_data(k_inc_s);
                    id_d   = IdWidth'(k_inc_s);
                end else begin
                    state_d = state_q;
                end
            end
            TG_READ: begin
                if (gnt_i && last_s) begin
                    state_d = TG_DRAIN;
                    k_d     = '0;
                    req_d   = 1'b0;
                    add_d   = '0;
                    be_d    = '0;
                    id_d    = '0;
                end else if (gnt_i) begin
                    k_d   = k_inc_s;
                    add_d = word_addr(k_inc_s);
                    id_d  = IdWidth'(k_inc_s);
                end else begin
                    state_d = state_q;
                end
            end
            TG_DRAIN: begin
                // Uses the post-update count so a response on this edge counts.
                if (rsp_cnt_next_s == ErrCntWidth'(NumWords)) begin
                    state_d = TG_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = TG_IDLE;
                k_d     = '0;
                req_d   = 1'b0;
                wen_d   = 1'b1;
                add_d   = '0;
                data_d  = '0;
                be_d    = '0;
                id_d    = '0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // FSM and registered request outputs, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= TG_IDLE;
            k_q     <= '0;
            req_q   <= 1'b0;
            wen_q   <= 1'b1;
            add_q   <= '0;
            data_q  <= '0;
            be_q    <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            req_q   <= req_d;
            wen_q   <= wen_d;
            add_q   <= add_d;
            data_q  <= data_d;
            be_q    <= be_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    tcdm_traffic_checker #(
        .NumWords (NumWords),
        .BaseAddr (BaseAddr),
        .DataWidth(DataWidth),
        .AddrWidth(AddrWidth),
        .IdWidth  (IdWidth),
        .Seed     (Seed),
        .CntWidth (CntWidth)
    ) u_checker (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (start_s),
        .active_i      (active_s),
        .r_valid_i     (r_valid_i),
        .r_data_i      (r_data_i),
        .r_id_i        (r_id_i),
        .err_cnt_o     (err_cnt_o),
        .rsp_cnt_o     (rsp_cnt_o),
        .rsp_cnt_next_o(rsp_cnt_next_s)
    );

    assign req_o     = req_q;
    assign wen_o     = wen_q;
    assign add_o     = add_q;
    assign data_o    = data_q;
    assign be_o      = be_q;
    assign id_o      = id_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign r_ready_o = 1'b1;

endmodule

// File: tb/tb_tcdm_traffic_gen.sv
// Directed bench for tcdm_traffic_gen with a one-cycle-latency bank model
// driven from the negative clock edge.
module tb_tcdm_traffic_gen;
    import tcdm_traffic_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni, start_i, gnt_i, r_valid_i, r_id_i;
    logic [31:0] r_data_i;
    logic        req_o, wen_o, id_o, r_ready_o, busy_o, done_o;
    logic [31:0] add_o, data_o;
    logic [3:0]  be_o;
    logic [15:0] err_cnt_o, rsp_cnt_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [16];
    bit          rand_gnt, flip5, bad_id, spur, pend_valid, stall_seen;
    logic [31:0] pend_data, st_add, st_data;
    logic        pend_id, st_wen;
    int          resp_num, tick_no, n_wr, n_rd, wr_first, wr_last, rd_first, rd_last;

    always #5 clk_i = ~clk_i;

    tcdm_traffic_gen u_dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .req_o    (req_o),
        .gnt_i    (gnt_i),
        .add_o    (add_o),
        .wen_o    (wen_o),
        .data_o   (data_o),
        .be_o     (be_o),
        .id_o     (id_o),
        .r_data_i (r_data_i),
        .r_valid_i(r_valid_i),
        .r_id_i   (r_id_i),
        .r_ready_o(r_ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_cnt_o(err_cnt_o),
        .rsp_cnt_o(rsp_cnt_o)
    );

    // One cycle of the bank model: drive response, pick grant, record the request.
    task automatic tick();
        @(negedge clk_i);
        tick_no++;
        if (stall_seen && rst_ni) begin
            checks++;
            if (add_o !== st_add || data_o !== st_data || wen_o !== st_wen) begin
                errors++;
                $display("FAIL stall_hold: add=%h data=%h wen=%b, expected add=%h data=%h wen=%b",
                         add_o, data_o, wen_o, st_add, st_data, st_wen);
            end
        end
        r_valid_i = pend_valid || spur;
        r_data_i  = pend_valid ? pend_data : 32'h0;
        r_id_i    = pend_id;
        if (pend_valid) begin
            if (flip5 && resp_num == 4) r_data_i[0] = ~r_data_i[0];
            if (bad_id) r_id_i = ~pend_id;
            resp_num++;
        end
        spur       = 1'b0;
        gnt_i      = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
        pend_valid = req_o && gnt_i && wen_o;
        pend_data  = mem[add_o[5:2]];
        pend_id    = id_o;
        if (req_o && gnt_i && !wen_o) begin
            mem[add_o[5:2]] = data_o;
            n_wr++;
            if (n_wr == 1) wr_first = tick_no;
            wr_last = tick_no;
        end else if (req_o && gnt_i) begin
            n_rd++;
            if (n_rd == 1) rd_first = tick_no;
            rd_last = tick_no;
        end
        stall_seen = req_o && !gnt_i;
        st_add     = add_o;
        st_data    = data_o;
        st_wen     = wen_o;
    endtask

    task automatic run_to_done(input bit hold, output int cyc);
        n_wr = 0; n_rd = 0; resp_num = 0; tick_no = 0; cyc = 0;
        start_i = 1'b1;
        do begin
            tick();
            cyc++;
            if (!hold) start_i = 1'b0;
        end while (!done_o && cyc < 200);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) tick();
        checks++;
        if (req_o !== 1'b0 || wen_o !== 1'b1 || add_o !== 32'h0 || data_o !== 32'h0 ||
            be_o !== 4'h0 || id_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: req=%b wen=%b add=%h data=%h be=%h id=%b, expected 0 1 0 0 0 0",
                     req_o, wen_o, add_o, data_o, be_o, id_o);
        end
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || r_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: busy=%b done=%b r_ready=%b, expected 0 0 1",
                     busy_o, done_o, r_ready_o);
        end
        checks++;
        if (err_cnt_o !== 16'd0 || rsp_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: err=%0d rsp=%0d, expected 0 0", err_cnt_o, rsp_cnt_o);
        end
        rst_ni = 1'b1;
        tick();
        checks++;
        if (req_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: req=%b busy=%b, expected 0 0", req_o, busy_o);
        end
    endtask

    task automatic test_spurious();
        spur = 1'b1;
        tick();
        tick();
        checks++;
        if (err_cnt_o !== 16'd1 || rsp_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL spurious_idle: err=%0d rsp=%0d, expected 1 0", err_cnt_o, rsp_cnt_o);
        end
    endtask

    task automatic test_full_grant();
        int cyc;
        rand_gnt = 1'b0;
        run_to_done(1'b0, cyc);
        checks++;
        if (done_o !== 1'b1 || cyc > 34) begin
            errors++;
            $display("FAIL full_done_latency: done=%b cycles=%0d, expected done=1 within 34", done_o, cyc);
        end
        checks++;
        if (err_cnt_o !== 16'd0 || rsp_cnt_o !== 16'd16 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL full_counts: err=%0d rsp=%0d busy=%b, expected 0 16 0", err_cnt_o, rsp_cnt_o, busy_o);
        end
        checks++;
        if (n_wr != 16 || wr_last - wr_first != 15 || n_rd != 16 || rd_first != wr_last + 1 ||
            rd_last - rd_first != 15) begin
            errors++;
            $display("FAIL full_b2b: wr=%0d [%0d..%0d] rd=%0d [%0d..%0d], expected 16 consecutive each, reads right after writes",
                     n_wr, wr_first, wr_last, n_rd, rd_first, rd_last);
        end
        checks++;
        if (mem[0] !== 32'hA5A5_5A5A || mem[5] !== 32'hA5A5_5A4E || mem[15] !== 32'hA5A5_5A66) begin
            errors++;
            $display("FAIL full_pattern: mem0=%h mem5=%h mem15=%h, expected a5a55a5a a5a55a4e a5a55a66",
                     mem[0], mem[5], mem[15]);
        end
    endtask

    task automatic test_random_gnt();
        int cyc;
        rand_gnt = 1'b1;
        run_to_done(1'b0, cyc);
        rand_gnt   = 1'b0;
        stall_seen = 1'b0;
        checks++;
        if (done_o !== 1'b1 || err_cnt_o !== 16'd0 || rsp_cnt_o !== 16'd16) begin
            errors++;
            $display("FAIL random_gnt: done=%b err=%0d rsp=%0d, expected 1 0 16", done_o, err_cnt_o, rsp_cnt_o);
        end
    endtask

    task automatic test_data_flip();
        int cyc;
        flip5 = 1'b1;
        run_to_done(1'b0, cyc);
        flip5 = 1'b0;
        checks++;
        if (done_o !== 1'b1 || err_cnt_o !== 16'd1 || rsp_cnt_o !== 16'd16) begin
            errors++;
            $display("FAIL data_flip: done=%b err=%0d rsp=%0d, expected 1 1 16", done_o, err_cnt_o, rsp_cnt_o);
        end
    endtask

    task automatic test_id_corrupt();
        int cyc;
        bad_id = 1'b1;
        run_to_done(1'b0, cyc);
        bad_id = 1'b0;
        checks++;
        if (done_o !== 1'b1 || err_cnt_o !== 16'd16) begin
            errors++;
            $display("FAIL id_corrupt: done=%b err=%0d, expected 1 16", done_o, err_cnt_o);
        end
    endtask

    task automatic test_start_held();
        int cyc;
        flip5 = 1'b1;
        run_to_done(1'b1, cyc);
        flip5 = 1'b0;
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || err_cnt_o !== 16'd1 || n_wr != 16 || n_rd != 16 || cyc > 34) begin
            errors++;
            $display("FAIL held_no_restart: done=%b busy=%b err=%0d wr=%0d rd=%0d cycles=%0d, expected 1 0 1 16 16 <=34",
                     done_o, busy_o, err_cnt_o, n_wr, n_rd, cyc);
        end
        tick();
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0 || err_cnt_o !== 16'd0 || rsp_cnt_o !== 16'd0 || req_o !== 1'b1) begin
            errors++;
            $display("FAIL held_restart: busy=%b done=%b err=%0d rsp=%0d req=%b, expected 1 0 0 0 1",
                     busy_o, done_o, err_cnt_o, rsp_cnt_o, req_o);
        end
        run_to_done(1'b0, cyc);
        checks++;
        if (done_o !== 1'b1 || err_cnt_o !== 16'd0 || rsp_cnt_o !== 16'd16) begin
            errors++;
            $display("FAIL held_second_run: done=%b err=%0d rsp=%0d, expected 1 0 16", done_o, err_cnt_o, rsp_cnt_o);
        end
    endtask

    task automatic test_reset_mid_read();
        int guard;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        guard = 0;
        while (!(req_o && wen_o && add_o == 32'd28) && guard < 100) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL reach_read7: add=%h wen=%b, expected read of 0000001c offered", add_o, wen_o);
        end
        rst_ni     = 1'b0;
        pend_valid = 1'b0;
        tick();
        rst_ni = 1'b1;
        checks++;
        if (req_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || err_cnt_o !== 16'd0 || rsp_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: req=%b busy=%b done=%b err=%0d rsp=%0d, expected 0 0 0 0 0",
                     req_o, busy_o, done_o, err_cnt_o, rsp_cnt_o);
        end
        checks++;
        if (u_dut.state_q !== TG_IDLE) begin
            errors++;
            $display("FAIL mid_reset_state: state=%0d, expected %0d", u_dut.state_q, TG_IDLE);
        end
        tick();
        checks++;
        if (req_o !== 1'b0 || busy_o !== 1'b0 || err_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_stays_idle: req=%b busy=%b err=%0d, expected 0 0 0", req_o, busy_o, err_cnt_o);
        end
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; gnt_i = 1'b0;
        r_valid_i = 1'b0; r_data_i = 32'h0; r_id_i = 1'b0;
        rand_gnt = 1'b0; flip5 = 1'b0; bad_id = 1'b0; spur = 1'b0;
        pend_valid = 1'b0; stall_seen = 1'b0; pend_data = 32'h0; pend_id = 1'b0;
        st_add = 32'h0; st_data = 32'h0; st_wen = 1'b1;
        resp_num = 0; tick_no = 0; n_wr = 0; n_rd = 0;
        wr_first = 0; wr_last = 0; rd_first = 0; rd_last = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset();
        test_spurious();
        test_full_grant();
        test_random_gnt();
        test_data_flip();
        test_id_corrupt();
        test_start_held();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
